// File: rtl/memory_map_reader.sv
// ============================================================================
//  Module      : memory_map_reader
//  Description : Memory-mapped register file with a 3-state load FSM,
//                store-to-load forwarding and a read-only STATUS register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_map_reader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
   parameter int          NUM_REGS  = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Write_Ena,
   input  logic [31:0] Write_addr,
   input  logic [31:0] Write_data,
   input  logic        Read_Ena,
   input  logic [31:0] Read_addr,
   output logic        Read_ready,
   output logic        Read_valid,
   output logic [31:0] Read_data,
   output logic        Read_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [31:0] c_STATUS_OFF = 32'(4 * NUM_REGS);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_regs [NUM_REGS];
   logic [7:0]  r_wr_count;
   logic        r_err_seen;
   logic [31:0] r_addr;
   logic [31:0] r_rdata;
   logic        r_rerr;

   logic [31:0] w_wr_off;
   logic        w_wr_hit;
   logic [7:0]  w_wr_count_nxt;
   logic [31:0] w_rd_off;
   logic        w_rd_data_hit;
   logic        w_rd_stat_hit;
   logic [31:0] w_rd_reg;
   logic [31:0] w_rd_data;
   logic        w_rd_err;

   // Offsets are full-width byte offsets, so an address below BASE_ADDR
   // wraps to a huge value and can never alias onto a register.
   assign w_wr_off = Write_addr - BASE_ADDR;
   assign w_wr_hit = Write_Ena && (Write_addr >= BASE_ADDR) &&
                     (Write_addr[1:0] == 2'b00) && (w_wr_off < c_STATUS_OFF);
   assign w_wr_count_nxt = (w_wr_hit && (r_wr_count != 8'hFF)) ?
                           r_wr_count + 8'd1 : r_wr_count;

   assign w_rd_off      = r_addr - BASE_ADDR;
   assign w_rd_data_hit = (r_addr >= BASE_ADDR) && (r_addr[1:0] == 2'b00) &&
                          (w_rd_off < c_STATUS_OFF);
   assign w_rd_stat_hit = (r_addr >= BASE_ADDR) && (w_rd_off == c_STATUS_OFF);
   assign w_rd_err      = !(w_rd_data_hit || w_rd_stat_hit);

   always_comb begin
      w_rd_reg = 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_rd_off == 32'(4 * i)) begin
            w_rd_reg = r_regs[i];
         end
      end
   end

   // A store landing in the LOOKUP cycle is forwarded; STATUS reflects
   // the count including that concurrent store.
   always_comb begin
      w_rd_data = 32'h0;
      if (w_rd_stat_hit) begin
         w_rd_data = {23'b0, r_err_seen, w_wr_count_nxt};
      end else if (w_rd_data_hit) begin
         if (w_wr_hit && (Write_addr == r_addr)) begin
            w_rd_data = Write_data;
         end else begin
            w_rd_data = w_rd_reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (Read_Ena) w_state_nxt = LOOKUP;
         LOOKUP:  w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= 32'h0;
      end else if ((r_state == IDLE) && Read_Ena) begin
         r_addr <= Read_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= 32'h0;
         end
         r_wr_count <= 8'h0;
      end else if (w_wr_hit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_off == 32'(4 * i)) begin
               r_regs[i] <= Write_data;
            end
         end
         r_wr_count <= w_wr_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata    <= 32'h0;
         r_rerr     <= 1'b0;
         r_err_seen <= 1'b0;
      end else if (r_state == LOOKUP) begin
         r_rdata <= w_rd_data;
         r_rerr  <= w_rd_err;
         if (w_rd_err) begin
            r_err_seen <= 1'b1;
         end
      end
   end

   assign Read_ready = (r_state == IDLE);
   assign Read_valid = (r_state == RESP);
   assign Read_data  = r_rdata;
   assign Read_err   = r_rerr;

endmodule

`default_nettype wire

// File: tb/tb_memory_map_reader.sv
// ============================================================================
//  Module      : tb_memory_map_reader
//  Description : Directed self-checking bench for memory_map_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_map_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        Write_Ena;
   logic [31:0] Write_addr;
   logic [31:0] Write_data;
   logic        Read_Ena;
   logic [31:0] Read_addr;
   logic        Read_ready;
   logic        Read_valid;
   logic [31:0] Read_data;
   logic        Read_err;

   int n_checks = 0;
   int n_fail   = 0;

   memory_map_reader dut (
      .clk        (clk),
      .rst        (rst),
      .Write_Ena  (Write_Ena),
      .Write_addr (Write_addr),
      .Write_data (Write_data),
      .Read_Ena   (Read_Ena),
      .Read_addr  (Read_addr),
      .Read_ready (Read_ready),
      .Read_valid (Read_valid),
      .Read_data  (Read_data),
      .Read_err   (Read_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      Write_Ena  = 1'b1;
      Write_addr = addr;
      Write_data = data;
      step();
      Write_Ena  = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      while (!Read_ready && k < 10) begin
         step();
         k++;
      end
      if (!Read_ready) chk({tag, "_ready_timeout"}, {31'b0, Read_ready}, 32'd1);
   endtask

   // Accept, then expect valid exactly two edges later with the given response.
   task automatic load(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_data, input logic exp_err);
      wait_ready(tag);
      Read_Ena  = 1'b1;
      Read_addr = addr;
      step();
      Read_Ena  = 1'b0;
      chk({tag, "_c1"}, {30'b0, Read_ready, Read_valid}, 32'd0);
      step();
      chk({tag, "_c2"}, {30'b0, Read_ready, Read_valid}, 32'd1);
      chk({tag, "_data"}, Read_data, exp_data);
      chk({tag, "_err"}, {31'b0, Read_err}, {31'b0, exp_err});
      step();
      chk({tag, "_c3"}, {30'b0, Read_ready, Read_valid}, 32'd2);
   endtask

   initial begin
      int vcnt;
      rst        = 1'b1;
      Write_Ena  = 1'b0;
      Write_addr = 32'h0;
      Write_data = 32'h0;
      Read_Ena   = 1'b0;
      Read_addr  = 32'h0;
      step();
      step();
      rst = 1'b0;
      chk("rst_ready", {31'b0, Read_ready}, 32'd1);
      chk("rst_valid", {31'b0, Read_valid}, 32'd0);
      chk("rst_data",  Read_data, 32'h0);
      chk("rst_err",   {31'b0, Read_err}, 32'd0);

      load("ld4008", 32'h4008, 32'h0, 1'b0);

      store(32'h4004, 32'hDEADBEEF);
      load("ld4004", 32'h4004, 32'hDEADBEEF, 1'b0);
      load("stat1",  32'h4014, 32'h0000_0001, 1'b0);

      load("ld4018", 32'h4018, 32'h0, 1'b1);
      load("ld4002", 32'h4002, 32'h0, 1'b1);
      load("stat2",  32'h4014, 32'h0000_0101, 1'b0);
      load("ld3ffc", 32'h3FFC, 32'h0, 1'b1);

      // Store to the captured address during LOOKUP must be forwarded.
      Read_Ena  = 1'b1;
      Read_addr = 32'h4010;
      step();
      Read_Ena   = 1'b0;
      Write_Ena  = 1'b1;
      Write_addr = 32'h4010;
      Write_data = 32'h12345678;
      step();
      Write_Ena = 1'b0;
      chk("fwd_valid", {31'b0, Read_valid}, 32'd1);
      chk("fwd_data",  Read_data, 32'h12345678);
      step();
      load("ld4010", 32'h4010, 32'h12345678, 1'b0);

      // STATUS read with a concurrent mapped store shows the new count.
      Read_Ena  = 1'b1;
      Read_addr = 32'h4014;
      step();
      Read_Ena   = 1'b0;
      Write_Ena  = 1'b1;
      Write_addr = 32'h4000;
      Write_data = 32'h0000_00A5;
      step();
      Write_Ena = 1'b0;
      chk("stfwd_valid", {31'b0, Read_valid}, 32'd1);
      chk("stfwd_data",  Read_data, 32'h0000_0103);
      step();

      store(32'h4014, 32'hFFFF_FFFF);
      store(32'h4001, 32'h1111_1111);
      store(32'h4018, 32'h2222_2222);
      load("ld4000", 32'h4000, 32'h0000_00A5, 1'b0);
      load("stat3",  32'h4014, 32'h0000_0103, 1'b0);

      // Continuous Read_Ena: one response every third cycle.
      Read_Ena  = 1'b1;
      Read_addr = 32'h4004;
      vcnt = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (Read_valid) begin
            vcnt++;
            chk("cont_data", Read_data, 32'hDEADBEEF);
         end
         chk("cont_pattern", {31'b0, Read_valid}, (i % 3 == 1) ? 32'd1 : 32'd0);
      end
      Read_Ena = 1'b0;
      chk("cont_count", vcnt, 32'd3);

      for (int i = 0; i < 300; i++) begin
         store(32'h4000, 32'(i));
      end
      load("sat_stat", 32'h4014, 32'h0000_01FF, 1'b0);
      store(32'h4014, 32'h0);
      load("sat_stat2", 32'h4014, 32'h0000_01FF, 1'b0);
      load("sat_reg",   32'h4000, 32'h0000_012B, 1'b0);

      // Reset in LOOKUP aborts the load.
      Read_Ena  = 1'b1;
      Read_addr = 32'h4004;
      step();
      Read_Ena = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_valid", {31'b0, Read_valid}, 32'd0);
      chk("abort_ready", {31'b0, Read_ready}, 32'd1);
      chk("abort_data",  Read_data, 32'h0);
      step();
      chk("abort_valid2", {31'b0, Read_valid}, 32'd0);
      load("post_4000", 32'h4000, 32'h0, 1'b0);
      load("post_4004", 32'h4004, 32'h0, 1'b0);
      load("post_4010", 32'h4010, 32'h0, 1'b0);
      load("post_stat", 32'h4014, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
